// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
//   Issue/collect controller wrapped around an external combinational ALU.
//   Accepts one decoded instruction bundle per handshake, maps the RISC-V
//   opcode/funct fields onto the ALU's 4-bit operation code, registers the
//   operands toward the ALU, captures the ALU result one cycle later and
//   returns a registered response (result, zero, branch decision, illegal)
//   under valid/ready backpressure.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   in_valid / in_ready      instruction bundle handshake
//   opcode, funct3, funct7_5 instruction fields instr[6:0], [14:12], [30]
//   rs1_val, rs2_val, imm    source operands and sign-extended immediate
//   op1, op2, alu_op         registered drive toward the ALU
//   alu_result, alu_zero     ALU outputs, sampled one cycle after accept
//   out_valid / out_ready    response handshake
//   out_result, out_zero     captured ALU result / zero flag
//   out_taken, out_illegal   branch decision, unsupported-instruction flag
//   retired_cnt              number of delivered responses (wraps)
// -----------------------------------------------------------------------------
module alu_issue_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic [WIDTH-1:0] rs1_val,
  input  logic [WIDTH-1:0] rs2_val,
  input  logic [WIDTH-1:0] imm,
  output logic [WIDTH-1:0] op1,
  output logic [WIDTH-1:0] op2,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_taken,
  output logic             out_illegal,
  output logic [15:0]      retired_cnt
);

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_LSR  = 4'b1000;
  localparam logic [3:0] ALU_LSL  = 4'b1001;
  localparam logic [3:0] ALU_ARSR = 4'b1010;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_e;

  // How the captured ALU result turns into a branch decision.
  typedef enum logic [2:0] {BR_NONE, BR_EQ, BR_NE, BR_LT, BR_GE} br_kind_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] op1_q, op1_d;
  logic [WIDTH-1:0] op2_q, op2_d;
  logic [3:0]       alu_op_q, alu_op_d;
  br_kind_e         br_q, br_d;
  logic             illegal_q, illegal_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_result_q, out_result_d;
  logic             out_zero_q, out_zero_d;
  logic             out_taken_q, out_taken_d;
  logic             out_illegal_q, out_illegal_d;
  logic [15:0]      retired_cnt_q, retired_cnt_d;

  // Decoded view of the bundle currently on the inputs.
  logic [WIDTH-1:0] dec_op2;
  logic [3:0]       dec_alu_op;
  br_kind_e         dec_br;
  logic             dec_illegal;

  // NOTE: every signal written in an always_comb gets a default on entry, so
  // no path through the case statements can leave it unassigned (no latch).
  always_comb begin
    dec_op2     = rs2_val;
    dec_alu_op  = ALU_ADD;
    dec_br      = BR_NONE;
    dec_illegal = 1'b0;
    unique case (opcode)
      OPC_OP, OPC_OPIMM: begin
        if (opcode == OPC_OPIMM) dec_op2 = imm;
        unique case (funct3)
          // funct7_5 means SUB only for register-register; ADDI ignores it.
          3'b000:  dec_alu_op = (opcode == OPC_OP && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b111:  dec_alu_op = ALU_AND;
          3'b110:  dec_alu_op = ALU_OR;
          3'b100:  dec_alu_op = ALU_XOR;
          3'b010:  dec_alu_op = ALU_SLT;
          3'b001:  dec_alu_op = ALU_LSL;
          3'b101:  dec_alu_op = funct7_5 ? ALU_ARSR : ALU_LSR;
          default: dec_illegal = 1'b1;
        endcase
      end
      OPC_LOAD, OPC_STORE: dec_op2 = imm;
      OPC_BRANCH: begin
        unique case (funct3)
          3'b000:  begin dec_alu_op = ALU_SUB; dec_br = BR_EQ; end
          3'b001:  begin dec_alu_op = ALU_SUB; dec_br = BR_NE; end
          3'b100:  begin dec_alu_op = ALU_SLT; dec_br = BR_LT; end
          3'b101:  begin dec_alu_op = ALU_SLT; dec_br = BR_GE; end
          default: dec_illegal = 1'b1;
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // Next-state and datapath update.
  always_comb begin
    state_d       = state_q;
    op1_d         = op1_q;
    op2_d         = op2_q;
    alu_op_d      = alu_op_q;
    br_d          = br_q;
    illegal_d     = illegal_q;
    out_valid_d   = out_valid_q;
    out_result_d  = out_result_q;
    out_zero_d    = out_zero_q;
    out_taken_d   = out_taken_q;
    out_illegal_d = out_illegal_q;
    retired_cnt_d = retired_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          // Illegal bundles still go through the ALU, but as a harmless 0 AND 0.
          op1_d     = dec_illegal ? '0 : rs1_val;
          op2_d     = dec_illegal ? '0 : dec_op2;
          alu_op_d  = dec_illegal ? ALU_AND : dec_alu_op;
          br_d      = dec_illegal ? BR_NONE : dec_br;
          illegal_d = dec_illegal;
          state_d   = S_EXEC;
        end
      end
      S_EXEC: begin
        out_result_d  = illegal_q ? '0 : alu_result;
        out_zero_d    = illegal_q ? 1'b1 : alu_zero;
        out_illegal_d = illegal_q;
        unique case (br_q)
          BR_EQ:   out_taken_d = alu_zero;
          BR_NE:   out_taken_d = !alu_zero;
          BR_LT:   out_taken_d = alu_result[0];
          BR_GE:   out_taken_d = !alu_result[0];
          default: out_taken_d = 1'b0;
        endcase
        out_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (out_ready) begin
          out_valid_d   = 1'b0;
          retired_cnt_d = retired_cnt_q + 16'd1;
          state_d       = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments only, so every flop
  // samples its _d value from before the edge regardless of block ordering.
  // NOTE: every register here is reset, including the internal branch/illegal
  // context, so a reset mid-operation leaves nothing stale behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      op1_q         <= '0;
      op2_q         <= '0;
      alu_op_q      <= ALU_AND;
      br_q          <= BR_NONE;
      illegal_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_zero_q    <= 1'b0;
      out_taken_q   <= 1'b0;
      out_illegal_q <= 1'b0;
      retired_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      op1_q         <= op1_d;
      op2_q         <= op2_d;
      alu_op_q      <= alu_op_d;
      br_q          <= br_d;
      illegal_q     <= illegal_d;
      out_valid_q   <= out_valid_d;
      out_result_q  <= out_result_d;
      out_zero_q    <= out_zero_d;
      out_taken_q   <= out_taken_d;
      out_illegal_q <= out_illegal_d;
      retired_cnt_q <= retired_cnt_d;
    end
  end

  // in_ready is gated by rst so nothing is offered while reset is applied.
  assign in_ready    = (state_q == S_IDLE) && !rst;
  assign op1         = op1_q;
  assign op2         = op2_q;
  assign alu_op      = alu_op_q;
  assign out_valid   = out_valid_q;
  assign out_result  = out_result_q;
  assign out_zero    = out_zero_q;
  assign out_taken   = out_taken_q;
  assign out_illegal = out_illegal_q;
  assign retired_cnt = retired_cnt_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_ctrl
//   Bench for alu_issue_ctrl. A behavioural ALU answers the DUT's op1/op2/
//   alu_op; expected values come from a mnemonic-level model that evaluates
//   each instruction directly from its source values.
// -----------------------------------------------------------------------------
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic [31:0] rs1_val, rs2_val, imm;
  logic [31:0] op1, op2;
  logic [3:0]  alu_op;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero, out_taken, out_illegal;
  logic [15:0] retired_cnt;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_cnt = '0;

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  aluop;
    logic        ill;
    logic [31:0] res;
    logic        zero;
    logic        taken;
  } exp_t;

  alu_issue_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm),
    .op1(op1), .op2(op2), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_taken(out_taken),
    .out_illegal(out_illegal), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural ALU attached to the DUT.
  always_comb begin
    case (alu_op)
      4'b0000: alu_result = op1 & op2;
      4'b0001: alu_result = op1 | op2;
      4'b0010: alu_result = op1 + op2;
      4'b0110: alu_result = op1 - op2;
      4'b0100: alu_result = ($signed(op1) < $signed(op2)) ? 32'd1 : 32'd0;
      4'b0101: alu_result = op1 ^ op2;
      4'b1000: alu_result = op1 >> op2[4:0];
      4'b1001: alu_result = op1 << op2[4:0];
      4'b1010: alu_result = $unsigned($signed(op1) >>> op2[4:0]);
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  // Instruction-level reference: name the instruction, then evaluate it.
  function automatic exp_t model(input logic [6:0] opc, input logic [2:0] f3,
                                 input logic f7, input logic [31:0] a,
                                 input logic [31:0] rb, input logic [31:0] im);
    exp_t  e;
    string mn;
    logic [31:0] b;
    b  = rb;
    mn = "ILL";
    case (opc)
      7'b0110011, 7'b0010011: begin
        if (opc == 7'b0010011) b = im;
        case (f3)
          3'd0: mn = (opc == 7'b0110011 && f7) ? "SUB" : "ADD";
          3'd7: mn = "AND";
          3'd6: mn = "OR";
          3'd4: mn = "XOR";
          3'd2: mn = "SLT";
          3'd1: mn = "SLL";
          3'd5: mn = f7 ? "SRA" : "SRL";
          default: mn = "ILL";
        endcase
      end
      7'b0000011, 7'b0100011: begin b = im; mn = "ADD"; end
      7'b1100011: begin
        case (f3)
          3'd0: mn = "BEQ";
          3'd1: mn = "BNE";
          3'd4: mn = "BLT";
          3'd5: mn = "BGE";
          default: mn = "ILL";
        endcase
      end
      default: mn = "ILL";
    endcase
    e.op1   = a;
    e.op2   = b;
    e.ill   = 1'b0;
    e.taken = 1'b0;
    case (mn)
      "ADD": begin e.aluop = 4'b0010; e.res = a + b; end
      "SUB": begin e.aluop = 4'b0110; e.res = a - b; end
      "AND": begin e.aluop = 4'b0000; e.res = a & b; end
      "OR":  begin e.aluop = 4'b0001; e.res = a | b; end
      "XOR": begin e.aluop = 4'b0101; e.res = a ^ b; end
      "SLT": begin e.aluop = 4'b0100; e.res = {31'd0, $signed(a) < $signed(b)}; end
      "SLL": begin e.aluop = 4'b1001; e.res = a << b[4:0]; end
      "SRL": begin e.aluop = 4'b1000; e.res = a >> b[4:0]; end
      "SRA": begin e.aluop = 4'b1010; e.res = $unsigned($signed(a) >>> b[4:0]); end
      "BEQ": begin e.aluop = 4'b0110; e.res = a - b; e.taken = (a == b); end
      "BNE": begin e.aluop = 4'b0110; e.res = a - b; e.taken = (a != b); end
      "BLT": begin e.aluop = 4'b0100; e.res = {31'd0, $signed(a) < $signed(b)};
                   e.taken = $signed(a) < $signed(b); end
      "BGE": begin e.aluop = 4'b0100; e.res = {31'd0, $signed(a) < $signed(b)};
                   e.taken = !($signed(a) < $signed(b)); end
      default: begin
        e.aluop = 4'b0000; e.op1 = '0; e.op2 = '0; e.res = '0; e.ill = 1'b1;
      end
    endcase
    e.zero = (e.res == 32'd0);
    return e;
  endfunction

  // Drive a bundle, check the accept and the EXEC capture.
  task automatic start_txn(input logic [6:0] opc, input logic [2:0] f3,
                           input logic f7, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] im,
                           input logic early_ready, output exp_t e);
    e = model(opc, f3, f7, a, b, im);
    for (int i = 0; i < 10 && !in_ready; i++) @(negedge clk);
    checks = checks + 1;
    if (in_ready !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL wait_in_ready: in_ready=%b required 1 within 10 cycles", in_ready);
    end
    opcode = opc; funct3 = f3; funct7_5 = f7;
    rs1_val = a; rs2_val = b; imm = im;
    in_valid = 1'b1;
    out_ready = early_ready;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checks = checks + 1;
    if ({op1, op2, alu_op} !== {e.op1, e.op2, e.aluop}) begin
      errors = errors + 1;
      $display("FAIL accept_operands: op1=%h op2=%h alu_op=%b required %h %h %b",
               op1, op2, alu_op, e.op1, e.op2, e.aluop);
    end
    checks = checks + 1;
    if ({in_ready, out_valid} !== 2'b00) begin
      errors = errors + 1;
      $display("FAIL exec_flags: in_ready=%b out_valid=%b required 0 0", in_ready, out_valid);
    end
    @(posedge clk);
    @(negedge clk);
    checks = checks + 1;
    if (out_valid !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL resp_valid: out_valid=%b required 1", out_valid);
    end
    checks = checks + 1;
    if ({out_result, out_zero, out_taken, out_illegal} !== {e.res, e.zero, e.taken, e.ill}) begin
      errors = errors + 1;
      $display("FAIL resp_fields: result=%h zero=%b taken=%b illegal=%b required %h %b %b %b",
               out_result, out_zero, out_taken, out_illegal, e.res, e.zero, e.taken, e.ill);
    end
    checks = checks + 1;
    if (retired_cnt !== exp_cnt) begin
      errors = errors + 1;
      $display("FAIL cnt_before_handshake: retired_cnt=%h required %h", retired_cnt, exp_cnt);
    end
  endtask

  // Stall for a number of cycles (with ignored in_valid), then handshake.
  task automatic finish_txn(input int stall, input exp_t e);
    out_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      opcode = 7'b0110011; funct3 = 3'($urandom); funct7_5 = 1'($urandom);
      rs1_val = $urandom; rs2_val = $urandom; imm = $urandom;
      @(posedge clk);
      @(negedge clk);
      checks = checks + 1;
      if ({out_valid, out_result, out_zero, out_taken, out_illegal, in_ready} !==
          {1'b1, e.res, e.zero, e.taken, e.ill, 1'b0}) begin
        errors = errors + 1;
        $display("FAIL stall_hold: valid=%b result=%h zero=%b taken=%b illegal=%b in_ready=%b required 1 %h %b %b %b 0",
                 out_valid, out_result, out_zero, out_taken, out_illegal, in_ready,
                 e.res, e.zero, e.taken, e.ill);
      end
      checks = checks + 1;
      if ({op1, op2, alu_op, retired_cnt} !== {e.op1, e.op2, e.aluop, exp_cnt}) begin
        errors = errors + 1;
        $display("FAIL stall_operands: op1=%h op2=%h alu_op=%b cnt=%h required %h %h %b %h",
                 op1, op2, alu_op, retired_cnt, e.op1, e.op2, e.aluop, exp_cnt);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    exp_cnt = exp_cnt + 16'd1;
    checks = checks + 1;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors = errors + 1;
      $display("FAIL handshake_flags: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
    checks = checks + 1;
    if (retired_cnt !== exp_cnt) begin
      errors = errors + 1;
      $display("FAIL retired_cnt: got %h required %h", retired_cnt, exp_cnt);
    end
  endtask

  task automatic run_txn(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im, input int stall);
    exp_t e;
    start_txn(opc, f3, f7, a, b, im, 1'b0, e);
    finish_txn(stall, e);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    opcode = '0; funct3 = '0; funct7_5 = 1'b0; rs1_val = '0; rs2_val = '0; imm = '0;
    repeat (2) @(negedge clk);
    checks = checks + 1;
    if ({op1, op2, alu_op, out_valid, out_result, out_zero, out_taken, out_illegal,
         retired_cnt} !== '0) begin
      errors = errors + 1;
      $display("FAIL reset_outputs: op1=%h op2=%h alu_op=%b valid=%b result=%h zero=%b taken=%b ill=%b cnt=%h required all 0",
               op1, op2, alu_op, out_valid, out_result, out_zero, out_taken, out_illegal, retired_cnt);
    end
    checks = checks + 1;
    if (in_ready !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL reset_in_ready: in_ready=%b required 0", in_ready);
    end
    rst = 1'b0;
    exp_cnt = '0;
    #1;
    checks = checks + 1;
    if (in_ready !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL release_in_ready: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_sub();
    run_txn(7'b0110011, 3'b000, 1'b1, 32'd5, 32'd5, $urandom, 0);
  endtask

  task automatic test_branch();
    run_txn(7'b1100011, 3'b100, 1'b0, 32'hFFFF_FFFF, 32'd1, $urandom, 0);  // BLT taken
    run_txn(7'b1100011, 3'b101, 1'b0, 32'hFFFF_FFFF, 32'd1, $urandom, 0);  // BGE not taken
    run_txn(7'b1100011, 3'b000, 1'b0, 32'd77, 32'd77, $urandom, 0);        // BEQ taken
    run_txn(7'b1100011, 3'b001, 1'b0, 32'd77, 32'd77, $urandom, 1);        // BNE not taken
  endtask

  task automatic test_opimm();
    run_txn(7'b0010011, 3'b101, 1'b1, 32'h8000_0F00, $urandom, 32'd4, 0);  // SRAI
    run_txn(7'b0010011, 3'b000, 1'b1, 32'd10, $urandom, 32'd3, 0);         // ADDI, f7_5 ignored
  endtask

  task automatic test_backpressure();
    run_txn(7'b0110011, 3'b110, 1'b0, $urandom, $urandom, $urandom, 5);
    run_txn(7'b1111111, 3'($urandom), 1'($urandom), $urandom, $urandom, $urandom, 1);
    run_txn(7'b0110011, 3'b011, 1'b0, $urandom, $urandom, $urandom, 0);   // OP f3=011
  endtask

  task automatic test_random();
    logic [6:0] opc;
    for (int n = 0; n < 40; n++) begin
      exp_t e;
      case ($urandom_range(0, 6))
        0:       opc = 7'b0110011;
        1:       opc = 7'b0010011;
        2:       opc = 7'b0000011;
        3:       opc = 7'b0100011;
        4, 5:    opc = 7'b1100011;
        default: opc = ($urandom_range(0, 1) == 0) ? 7'b1101111 : 7'b0110111;
      endcase
      start_txn(opc, 3'($urandom), 1'($urandom), $urandom,
                ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
                $urandom, 1'($urandom), e);
      finish_txn($urandom_range(0, 2), e);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    start_txn(7'b0110011, 3'b000, 1'b0, 32'd3, 32'd4, 32'd0, 1'b0, e);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks = checks + 1;
    if ({out_valid, retired_cnt, in_ready} !== {1'b0, 16'd0, 1'b0}) begin
      errors = errors + 1;
      $display("FAIL reset_in_resp: out_valid=%b cnt=%h in_ready=%b required 0 0000 0",
               out_valid, retired_cnt, in_ready);
    end
    rst = 1'b0;
    exp_cnt = '0;
    run_txn(7'b0000011, 3'($urandom), 1'($urandom), $urandom, $urandom, $urandom, 0);
  endtask

  task automatic test_wrap();
    force dut.retired_cnt_q = 16'hFFFF;
    #1;
    release dut.retired_cnt_q;
    exp_cnt = 16'hFFFF;
    run_txn(7'b0100011, 3'b010, 1'b0, $urandom, $urandom, $urandom, 0);
  endtask

  initial begin
    test_reset();
    test_sub();
    test_branch();
    test_opimm();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
